// File: rtl/aes_pkg.sv
// aes_pkg
// Shared definitions for the AES mode engine: block width, chaining-mode
// encodings, controller state encoding and the mode decode helper.
package aes_pkg;

  localparam int BLK_W = 128;

  typedef enum logic [1:0] {
    MODE_ECB = 2'b00,
    MODE_CBC = 2'b01,
    MODE_CTR = 2'b10
  } aes_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READY = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } aes_state_e;

  // The reserved encoding 2'b11 behaves as ECB.
  function automatic aes_mode_e decode_mode(input logic [1:0] m);
    case (m)
      2'b01:   return MODE_CBC;
      2'b10:   return MODE_CTR;
      default: return MODE_ECB;
    endcase
  endfunction

endpackage

// File: rtl/AES.sv
// AES
// Iterative AES-128 encryption core, one round per clock. A pulse on
// input_valid loads plain_text ^ key; ten rounds later output_valid pulses
// for one cycle with cipher_text. Round keys are expanded on the fly.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   input_valid    start an encryption of plain_text under key
//   key            128-bit cipher key
//   plain_text     128-bit input block
//   output_valid   one-cycle pulse when cipher_text is updated
//   cipher_text    128-bit result, held until the next completion
module AES (
  input  logic         clk,
  input  logic         rst,
  input  logic         input_valid,
  input  logic [127:0] key,
  input  logic [127:0] plain_text,
  output logic         output_valid,
  output logic [127:0] cipher_text
);

  logic [127:0] st;
  logic [127:0] rk;
  logic [127:0] rk_nxt;
  logic [127:0] st_nxt;
  logic [3:0]   rnd;
  logic         run;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as GF(2^8) inverse (x^254, 0 maps to 0) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      default: return 8'h36;
    endcase
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // Byte k of a block sits at bits [127-8k -: 8]; byte 4c+r is row r, column c.
  function automatic logic [127:0] aes_round(input logic [127:0] s,
                                             input logic [127:0] k,
                                             input logic         last);
    logic [7:0]   b [16];
    logic [7:0]   t [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int w = 0; w < 4; w++) t[4*c+w] = b[4*((c+w)%4)+w];
    for (int c = 0; c < 4; c++) begin
      a0 = t[4*c];
      a1 = t[4*c+1];
      a2 = t[4*c+2];
      a3 = t[4*c+3];
      if (last) begin
        r[127-32*c -: 32] = {a0, a1, a2, a3};
      end else begin
        r[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                             a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                             a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                             xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
      end
    end
    return r ^ k;
  endfunction

  always_comb begin
    rk_nxt = next_key(rk, rcon(rnd));
    st_nxt = aes_round(st, rk_nxt, rnd == 4'd10);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= '0;
      rk           <= '0;
      rnd          <= '0;
      run          <= 1'b0;
      output_valid <= 1'b0;
      cipher_text  <= '0;
    end else begin
      output_valid <= 1'b0;
      if (input_valid) begin
        st  <= plain_text ^ key;
        rk  <= key;
        rnd <= 4'd1;
        run <= 1'b1;
      end else if (run) begin
        st <= st_nxt;
        rk <= rk_nxt;
        if (rnd == 4'd10) begin
          run          <= 1'b0;
          output_valid <= 1'b1;
          cipher_text  <= st_nxt;
        end else begin
          rnd <= rnd + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/aes_blk_fifo.sv
// aes_blk_fifo
// Synchronous FIFO for cipher blocks. Read data is the head entry
// (combinational), so a block written in one cycle can be popped in the next.
// Ports:
//   clk, rst         clock, asynchronous active-high reset (flushes the FIFO)
//   wr_en, wr_data   push; ignored while full
//   rd_en, rd_data   pop; rd_data shows the head entry
//   full, empty      status flags
//   count            number of stored entries
module aes_blk_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 128,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  // Storage is not reset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/aes_mode_engine.sv
// aes_mode_engine
// Streaming AES-128 front-end: buffers input blocks in aes_blk_fifo, applies
// ECB, CBC-encrypt or CTR chaining around the iterative AES core and holds
// each result behind a valid/ready handshake. One block is in flight at a time.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, key, iv, mode  load key/chain/counter/mode (IDLE or READY only)
//   in_data, in_valid     input block stream; in_ready = FIFO not full
//   out_data, out_valid   result block, held until out_ready
//   busy                  block in flight or FIFO non-empty
//   blk_count             blocks completed since the last accepted start
//
// state | meaning
// IDLE  | no key loaded yet; FIFO may fill but nothing drains
// READY | key loaded; pop the next block or accept a reload
// ISSUE | core_in/key presented to the core for one cycle
// WAIT  | core running; result captured on core completion
// HOLD  | out_valid asserted until out_ready
module aes_mode_engine
  import aes_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CTR_WIDTH  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [BLK_W-1:0] key,
  input  logic [BLK_W-1:0] iv,
  input  logic [1:0]       mode,
  input  logic [BLK_W-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [BLK_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic [15:0]      blk_count
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  aes_state_e       state_r, state_nxt;
  aes_mode_e        mode_r;
  logic [BLK_W-1:0] key_r, chain_r, ctr_r, blk_r, core_in_r;
  logic [BLK_W-1:0] fifo_rdata, core_out, result, ctr_inc;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty, fifo_wr, fifo_rd;
  logic             start_ok, core_valid, core_done;

  assign in_ready = !fifo_full;
  assign fifo_wr  = in_valid && !fifo_full;

  aes_blk_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (BLK_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (fifo_wr),
    .wr_data (in_data),
    .rd_en   (fifo_rd),
    .rd_data (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  AES u_core (
    .clk          (clk),
    .rst          (rst),
    .input_valid  (core_valid),
    .key          (key_r),
    .plain_text   (core_in_r),
    .output_valid (core_done),
    .cipher_text  (core_out)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= IDLE;
    else     state_r <= state_nxt;
  end

  always_comb begin
    state_nxt = state_r;
    case (state_r)
      IDLE:    if (start) state_nxt = READY;
      READY:   if (!start && !fifo_empty) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (core_done) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = READY;
      default: state_nxt = IDLE;
    endcase
  end

  // A reload in READY takes priority over popping the next block.
  always_comb begin
    start_ok   = 1'b0;
    fifo_rd    = 1'b0;
    core_valid = 1'b0;
    busy       = (fifo_count != '0);
    case (state_r)
      IDLE:  start_ok = start;
      READY: begin
        start_ok = start;
        fifo_rd  = !start && !fifo_empty;
      end
      ISSUE: begin
        core_valid = 1'b1;
        busy       = 1'b1;
      end
      WAIT, HOLD: busy = 1'b1;
      default: ;
    endcase
  end

  // Only the low CTR_WIDTH counter bits roll over; the upper bits are a fixed nonce.
  always_comb begin
    ctr_inc                  = ctr_r;
    ctr_inc[CTR_WIDTH-1:0]   = ctr_r[CTR_WIDTH-1:0] + CTR_WIDTH'(1);
    result                   = (mode_r == MODE_CTR) ? (core_out ^ blk_r) : core_out;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_r     <= '0;
      chain_r   <= '0;
      ctr_r     <= '0;
      mode_r    <= MODE_ECB;
      blk_r     <= '0;
      core_in_r <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      blk_count <= '0;
    end else begin
      if (start_ok) begin
        key_r     <= key;
        chain_r   <= iv;
        ctr_r     <= iv;
        mode_r    <= decode_mode(mode);
        blk_count <= '0;
      end
      if (fifo_rd) begin
        blk_r <= fifo_rdata;
        case (mode_r)
          MODE_CBC: core_in_r <= fifo_rdata ^ chain_r;
          MODE_CTR: core_in_r <= ctr_r;
          default:  core_in_r <= fifo_rdata;
        endcase
      end
      if (state_r == WAIT && core_done) begin
        out_data  <= result;
        out_valid <= 1'b1;
        blk_count <= blk_count + 16'd1;
        if (mode_r == MODE_CBC) chain_r <= core_out;
        if (mode_r == MODE_CTR) ctr_r   <= ctr_inc;
      end
      if (state_r == HOLD && out_ready) out_valid <= 1'b0;
    end
  end

endmodule
